// File: rtl/fifo_serial_drain_pkg.sv
// Shared types and constants for the FIFO serial drain.
// Holds the FSM state encoding, the baud counter width and a frame-length helper.
package fifo_drain_pkg;

  localparam int unsigned BAUD_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } drain_state_e;

  // Serial bits per frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/fifo_serial_drain_if.sv
// FIFO read-side handshake between the drain (master) and the FIFO (slave).
interface fifo_serial_drain_if #(
  parameter int unsigned DATA_W = 4
);

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              fifo_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output fifo_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  fifo_en
  );

endinterface

// File: rtl/fifo_serial_drain_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, reloads on terminal count or clear.
// pre_tick_o flags the cycle before the terminal count so registered outputs can align to it.
module baud_tick_gen
  import fifo_drain_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam logic [BAUD_CNT_W-1:0] TermCnt = BAUD_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_CNT_W-1:0] PreCnt  = BAUD_CNT_W'(CLKS_PER_BIT - 2);

  logic [BAUD_CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + BAUD_CNT_W'(1);
    if (clr_i || (cnt_q == TermCnt)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o     = (cnt_q == TermCnt);
  assign pre_tick_o = (cnt_q == PreCnt);

endmodule

// File: rtl/fifo_serial_drain.sv
// Pops nibbles from a FIFO and shifts each out as an async serial frame
// (start, data LSB-first, optional parity, stop bits), one FIFO read per frame.
module fifo_serial_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                EN,
  fifo_serial_drain_if.master fifo,
  output logic                txd,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned BitCntW = $clog2(DATA_W) + 1;
  localparam logic [BitCntW-1:0] LastData = BitCntW'(DATA_W - 1);
  localparam logic [BitCntW-1:0] LastStop = BitCntW'(STOP_BITS - 1);
  localparam logic ParityInv = (PARITY_ODD != 0);

  drain_state_e        state_d, state_q;
  logic [DATA_W-1:0]   shreg_d, shreg_q;
  logic [BitCntW-1:0]  bit_cnt_d, bit_cnt_q;
  logic                parity_d, parity_q;
  logic                txd_d, txd_q;
  logic                rd_d, rd_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;
  logic                baud_clr;
  logic                tick;
  logic                pre_tick;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i     (Clk),
    .rst_ni    (Rst),
    .clr_i     (baud_clr),
    .tick_o    (tick),
    .pre_tick_o(pre_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    txd_d     = txd_q;
    rd_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (EN && !fifo.fifo_empty) begin
          state_d = POP;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d   = fifo.fifo_data;
        parity_d  = (^fifo.fifo_data) ^ ParityInv;
        bit_cnt_d = '0;
        baud_clr  = 1'b1;
        txd_d     = 1'b0;
        state_d   = START;
      end
      START: begin
        if (tick) begin
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              txd_d   = parity_q;
              state_d = PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // Registered pulse: raise one cycle early so it lands on the final stop cycle.
        done_d = pre_tick && (bit_cnt_q == LastStop);
        if (tick) begin
          if (bit_cnt_q == LastStop) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign txd          = txd_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign fifo.fifo_rd = rd_q;
  assign fifo.fifo_en = rd_q;

endmodule

// File: doc/fifo_serial_drain.md
Name: fifo_serial_drain

Overview:
- Downstream consumer of the 4-bit FIFO buffer.
- Pops one nibble at a time using the FIFO's RD/EMPTY/dataOut handshake.
- Shifts each nibble out as an asynchronous serial frame: start bit, data LSB-first, optional parity, stop bit(s).
- Sits between the FIFO and the off-chip TX pin. Throttles FIFO reads to line rate, so the FIFO absorbs producer bursts.

Parameters:
- DATA_W, 4: nibble width; must match the FIFO word width.
- CLKS_PER_BIT, 16: Clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 1: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  asynchronous, active-low reset.
- EN  in  1  drain enable; when low, no new frame is started.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_data  in  DATA_W  FIFO dataOut; registered in the FIFO, valid the cycle after RD.
- fifo_rd  out  1  FIFO RD strobe; one-cycle pulse per pop.
- fifo_en  out  1  FIFO EN; driven high whenever fifo_rd is high, otherwise low.
- txd  out  1  serial line; idle high.
- busy  out  1  high from POP through the end of the last stop bit.
- frame_done  out  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset, asynchronous on Rst low: state=IDLE, txd=1, fifo_rd=0, fifo_en=0, busy=0, frame_done=0, shift register=0, bit counter=0, baud counter=0. Takes effect mid-frame immediately; the partial frame is abandoned and no FIFO read is issued.
- IDLE: if EN=1 and fifo_empty=0, go to POP. Otherwise stay; txd=1.
- POP (1 cycle): fifo_rd=1, fifo_en=1, busy=1. Go to LOAD.
- LOAD (1 cycle): capture fifo_data into the shift register. Compute parity = XOR of the data, inverted if PARITY_ODD. Clear the baud counter. Go to START.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA: DATA_W bits LSB first, CLKS_PER_BIT cycles each. Bit counter runs 0..DATA_W-1.
- PARITY: present only if PARITY_EN. txd=parity for CLKS_PER_BIT cycles.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses on the last cycle. Then go to IDLE.
- Frame timing: each bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and its terminal count advances the bit. Counter width is 16 bits; it wraps only via terminal-count reload.
- Frame length: 1+DATA_W+PARITY_EN+STOP_BITS bits.
- Latency: from fifo_empty=0 seen in IDLE to the txd falling edge is 3 cycles (IDLE→POP→LOAD→START).
- Back-to-back: IDLE lasts exactly one cycle between frames. The continuous-stream period is (frame bits*CLKS_PER_BIT)+3 cycles.
- fifo_rd is never asserted while fifo_empty=1 or outside POP. It is asserted at most once per frame.
- EN falling mid-frame: the current frame completes normally; no new POP follows. EN is sampled only in IDLE.
- fifo_empty rising during a frame has no effect until IDLE.
- txd is registered, with no combinational path from inputs.

Decomposition:
- Shared package fifo_drain_pkg holds:
  - state enum {IDLE, POP, LOAD, START, DATA, PARITY, STOP};
  - the BAUD_CNT_W=16 constant;
  - a function computing frame bit count from the parameters.
- One sub-module, baud_tick_gen: counter with clear input and terminal-count tick output, parameterised by CLKS_PER_BIT.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=1 even, STOP_BITS=1. FIFO preloaded with 4'hA, EN=1 → fifo_rd pulses once. txd holds each bit 4 cycles: 0 (start), 0,1,0,1 (data), 0 (parity), 1 (stop). frame_done pulses at cycle 28 of the frame. busy then drops.
2. FIFO preloaded with 4'h1, 4'h7, 4'hF, streaming → exactly 3 fifo_rd pulses, spaced 31 cycles apart. Decoded nibbles are 1,7,F. Parity bits are 1,1,0. fifo_rd never pulses while fifo_empty=1.
3. Empty FIFO, EN=1 for 100 cycles → fifo_rd=0, txd=1, busy=0 throughout.
4. Rst driven low at data bit 2 of an 4'h5 frame, asynchronously mid-cycle → txd=1 and busy=0 immediately. After release, the next FIFO word is sent as a clean full frame.
5. EN dropped during the start bit of 4'h3, with FIFO holding more data → 4'h3 frame completes. No further fifo_rd while EN=0. Raising EN resumes with the next word.
6. PARITY_ODD=1, STOP_BITS=2, data 4'h0 → parity bit 1, then 8 cycles of stop high. frame_done on the final stop cycle.
